// File: rtl/barrel_shift_ctrl.sv
// Command queue and result register wrapped around an external 8-bit rotator.
// Optional BSC_DIR_EN adds i_dir; left rotates become right rotates by (8-k) mod 8.
module barrel_shift_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [7:0]                 i_data,
    input  logic [2:0]                 i_k,
`ifdef BSC_DIR_EN
    input  logic                       i_dir,
`endif
    output logic [7:0]                 o_sh_A,
    output logic [2:0]                 o_sh_k,
    input  logic [7:0]                 i_sh_Y,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [7:0]                 o_data,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] k;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    out_state_e    out_state_q, out_state_d;
    logic [7:0]    o_data_q, o_data_d;

    logic          push;
    logic          load;
    logic          has_head;
    logic [2:0]    k_eff;
    entry_t        head;

    // Both handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; o_ready depends on registered count only, never on a same-cycle pop.
    assign o_ready  = (count_q != LW'(DEPTH));
    assign has_head = (count_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign o_sh_A   = has_head ? head.data : 8'h00;
    assign o_sh_k   = has_head ? head.k    : 3'd0;
    assign o_valid  = (out_state_q == OUT_FULL);
    assign o_data   = o_data_q;
    assign o_level  = count_q;

    always_comb begin
        k_eff = i_k;
`ifdef BSC_DIR_EN
        if (i_dir) k_eff = 3'd0 - i_k;
`endif
        push = i_valid & o_ready;
        load = has_head & ((out_state_q == OUT_EMPTY) | i_ready);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{data: i_data, k: k_eff};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (load) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, load})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase

        out_state_d = out_state_q;
        o_data_d    = o_data_q;
        if (load) begin
            out_state_d = OUT_FULL;
            o_data_d    = i_sh_Y;
        end else if ((out_state_q == OUT_FULL) && i_ready) begin
            out_state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_state_q <= OUT_EMPTY;
            o_data_q    <= 8'h00;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_state_q <= out_state_d;
            o_data_q    <= o_data_d;
        end
    end

endmodule

// File: tb/tb_barrel_shift_ctrl.sv
// Bench for barrel_shift_ctrl: queue-level reference model plus directed literal checks.
// Build with +define+BSC_DIR_EN to exercise left rotates.
module tb_barrel_shift_ctrl;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [7:0] d;
        logic [2:0] k;
        logic       dir;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [7:0]    i_data;
    logic [2:0]    i_k;
    logic          i_dir;
    logic [7:0]    sh_a;
    logic [2:0]    sh_k;
    logic [7:0]    sh_y;
    logic          o_valid;
    logic          i_ready;
    logic [7:0]    o_data;
    logic [LW-1:0] o_level;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    bit   done     = 0;

    cmd_t       mq[$];
    logic [7:0] exp_q[$];
    logic       m_valid;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    barrel_shift_ctrl #(.DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_k     (i_k),
`ifdef BSC_DIR_EN
        .i_dir   (i_dir),
`endif
        .o_sh_A  (sh_a),
        .o_sh_k  (sh_k),
        .i_sh_Y  (sh_y),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_level (o_level)
    );

    function automatic logic [7:0] rotr(logic [7:0] d, int k);
        logic [15:0] w;
        w = {d, d} >> k;
        return w[7:0];
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] d, int k);
        logic [15:0] w;
        w = {d, d} << k;
        return w[15:8];
    endfunction

    function automatic logic [7:0] ref_rot(cmd_t c);
        return c.dir ? rotl(c.d, int'(c.k)) : rotr(c.d, int'(c.k));
    endfunction

    function automatic int ref_shk(cmd_t c);
        return c.dir ? (8 - int'(c.k)) % 8 : int'(c.k);
    endfunction

    // External rotator: right rotate of o_sh_A by o_sh_k.
    always_comb sh_y = rotr(sh_a, int'(sh_k));

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: command queue, output slot, and in-order result scoreboard.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
        end else begin
            bit   do_push, do_load;
            cmd_t c;
            do_push = i_valid && (mq.size() < DEPTH);
            do_load = (mq.size() > 0) && (!m_valid || i_ready);
            if (do_load) begin
                c       = mq.pop_front();
                m_valid = 1'b1;
                m_data  = ref_rot(c);
            end else if (m_valid && i_ready) begin
                m_valid = 1'b0;
            end
            if (do_push) begin
                c.d   = i_data;
                c.k   = i_k;
                c.dir = i_dir;
                mq.push_back(c);
                exp_q.push_back(ref_rot(c));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("o_valid", int'(o_valid), int'(m_valid));
            chk("o_data", int'(o_data), int'(m_data));
            chk("o_level", int'(o_level), mq.size());
            chk("o_ready", int'(o_ready), int'(mq.size() != DEPTH));
            if (mq.size() > 0) begin
                chk("o_sh_A", int'(sh_a), int'(mq[0].d));
                chk("o_sh_k", int'(sh_k), ref_shk(mq[0]));
            end else begin
                chk("o_sh_A_idle", int'(sh_a), 0);
                chk("o_sh_k_idle", int'(sh_k), 0);
            end
            if (o_valid && i_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else chk("sb_order", int'(o_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(logic [7:0] d, logic [2:0] k, logic dir);
        bit ok;
        i_valid = 1'b1;
        i_data  = d;
        i_k     = k;
`ifdef BSC_DIR_EN
        i_dir   = dir;
`else
        i_dir   = 1'b0;
`endif
        for (int t = 0; t < 100; t++) begin
            ok = o_ready;
            tick();
            if (ok) break;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        i_valid = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_k     = 3'd0;
        i_dir   = 1'b0;
        i_ready = 1'b1;
        #3;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_level", int'(o_level), 0);
        chk("rst_data", int'(o_data), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // Single right rotate: 0x81 >>> 1 = 0xC0, visible two edges after accept.
        send(8'h81, 3'd1, 1'b0);
        chk("r1_sh_k", int'(sh_k), 1);
        chk("r1_lat_early", int'(o_valid), 0);
        tick();
        chk("r1_valid", int'(o_valid), 1);
        chk("r1_data", int'(o_data), 8'hC0);
        tick();

`ifdef BSC_DIR_EN
        send(8'h81, 3'd1, 1'b1);
        chk("l1_sh_k", int'(sh_k), 7);
        tick();
        chk("l1_data", int'(o_data), 8'h03);
        send(8'h5A, 3'd0, 1'b1);
        chk("l0_sh_k", int'(sh_k), 0);
        tick();
        chk("l0_data", int'(o_data), 8'h5A);
        tick();
`endif

        // Backpressure: DEPTH in the FIFO plus one in the output register.
        i_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) send(8'(i), 3'd0, 1'b0);
        chk("full_ready", int'(o_ready), 0);
        chk("full_level", int'(o_level), DEPTH);
        chk("full_data", int'(o_data), 8'h01);
        chk("full_valid", int'(o_valid), 1);
        tick();
        chk("full_hold", int'(o_data), 8'h01);
        i_ready = 1'b1;
        for (int i = 2; i <= DEPTH + 1; i++) begin
            tick();
            chk("drain_order", int'(o_data), i);
        end
        tick();
        chk("drain_empty", int'(o_valid), 0);
        chk("drain_hold", int'(o_data), DEPTH + 1);

        // Streaming: one result per cycle once the pipe fills.
        for (int j = 0; j < 64; j++) begin
            send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (j > 0) chk("stream_nobubble", int'(o_valid), 1);
            chk("stream_level", int'(o_level <= LW'(1)), 1);
        end
        repeat (3) tick();

        // Reset in the middle of traffic.
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 3'd2, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_ready", int'(o_ready), 1);
        chk("mid_rst_level", int'(o_level), 0);
        chk("mid_rst_data", int'(o_data), 0);
        chk("mid_rst_sh_A", int'(sh_a), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        i_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", int'(o_valid), 0);

        // Random valid/ready toggling.
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    i_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        i_ready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
        tick();
        chk("final_drain", exp_q.size(), 0);
        chk("final_valid", int'(o_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
